// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready stream interface.
// Slice k adds operand bits [k*CW +: CW]; unprocessed upper operand bits and
// finished lower sum bits travel with the data so the result leaves aligned.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = WIDTH / ((STAGES < 1) ? 1 : STAGES);

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: illegal WIDTH/STAGES combination");
  end

  logic advance;

  // Skew registers shrink by CW per slice and deskew registers grow by CW,
  // so every slice only carries the bits it still needs.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    localparam int IW = WIDTH - k * CW;

    logic [IW-1:0]         xi;
    logic [IW-1:0]         ybi;
    logic                  vi;
    logic                  ci;
    logic [CW:0]           part;
    logic [(k+1)*CW-1:0]   s_new;
    logic                  v_q, v_d;
    logic                  c_q, c_d;
    logic [(k+1)*CW-1:0]   s_q, s_d;

    if (k == 0) begin : g_in
      assign vi    = in_valid;
      assign xi    = x;
      assign ybi   = sub ? ~y : y;
      assign ci    = c_in ^ sub;
      assign s_new = part[CW-1:0];
    end else begin : g_in
      assign vi    = g_slice[k-1].v_q;
      assign xi    = g_slice[k-1].g_fwd.xr_q;
      assign ybi   = g_slice[k-1].g_fwd.ybr_q;
      assign ci    = g_slice[k-1].c_q;
      assign s_new = {part[CW-1:0], g_slice[k-1].s_q};
    end

    assign part = {1'b0, xi[CW-1:0]} + {1'b0, ybi[CW-1:0]} + {{CW{1'b0}}, ci};

    // Slice result and valid load on advance, hold otherwise.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (advance) begin
        v_d = vi;
        c_d = part[CW];
        s_d = s_new;
      end
    end

    // Slice state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      localparam int RW = IW - CW;
      logic [RW-1:0] xr_q, xr_d;
      logic [RW-1:0] ybr_q, ybr_d;

      // Forward the not-yet-added operand bits.
      always_comb begin
        xr_d  = xr_q;
        ybr_d = ybr_q;
        if (advance) begin
          xr_d  = xi[IW-1:CW];
          ybr_d = ybi[IW-1:CW];
        end
      end

      // Operand skew register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xr_q  <= '0;
          ybr_q <= '0;
        end else begin
          xr_q  <= xr_d;
          ybr_q <= ybr_d;
        end
      end
    end else begin : g_last
      logic ovf_q, ovf_d;

      // Overflow is resolved in the slice that produces the MSB.
      always_comb begin
        ovf_d = ovf_q;
        if (advance) begin
          ovf_d = (xi[IW-1] == ybi[IW-1]) && (part[CW-1] != xi[IW-1]);
        end
      end

      // Overflow flag register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_slice[STAGES-1].v_q;
  assign sum       = g_slice[STAGES-1].s_q;
  assign c_out     = g_slice[STAGES-1].c_q;
  assign ovf       = g_slice[STAGES-1].g_last.ovf_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

endmodule
